// File: rtl/pipelined_reduce_tree.sv
// -----------------------------------------------------------------------------
// pipelined_reduce_tree
//
// Reduces an N-element vector to one scalar per beat, by sum or by max, using
// a binary tree with one register stage per level. All stages share a single
// advance signal (global stall). A valid/ready handshake is used on both sides.
//
// Optional feature macro: ADDER_TREE_ACCUM_EN
//   When defined, an accumulator stage follows the tree. It folds consecutive
//   tree results into one output per group, where a group is closed by last=1.
//   When undefined, every beat produces exactly one result and last passes
//   through unchanged.
//
// Parameters
//   N          number of input elements (>= 1)
//   DATA_WIDTH width of each input element
//   OUT_WIDTH  result width, >= DATA_WIDTH + $clog2(N)
//   SIGNED     1: elements are two's complement (sign extension, signed max)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   in_vector  N input elements, element i at in_vector[i]
//   in_mode    0 = sum, 1 = max; travels with the beat
//   in_last    group-end flag; travels with the beat
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   reduced result
//   out_last   group-end flag aligned with out_data
// -----------------------------------------------------------------------------
module pipelined_reduce_tree #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(N),
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vector [N-1:0],
  input  logic                  in_mode,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 1;

  typedef logic [OUT_WIDTH-1:0] word_t;

  // Elaboration-time parameter checks.
  if (N < 1) begin : g_bad_n
    $error("pipelined_reduce_tree: N must be at least 1");
  end
  if (OUT_WIDTH < DATA_WIDTH + $clog2(N)) begin : g_bad_width
    $error("pipelined_reduce_tree: OUT_WIDTH must be at least DATA_WIDTH+$clog2(N)");
  end

  // Number of registers held by level k: ceil(N / 2^(k+1)).
  function automatic int level_count(input int k);
    return (N + (1 << (k + 1)) - 1) >> (k + 1);
  endfunction

  // Number of operands feeding level k: ceil(N / 2^k).
  function automatic int level_inputs(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  // Widen one element to the result width.
  function automatic word_t extend(input logic [DATA_WIDTH-1:0] x);
    if (SIGNED != 0) begin
      return word_t'($signed(x));
    end
    return word_t'(x);
  endfunction

  // op(mode): sum wraps modulo 2^OUT_WIDTH; max honours SIGNED.
  function automatic word_t combine(input word_t a, input word_t b, input logic mode);
    if (!mode) begin
      return a + b;
    end
    if (SIGNED != 0) begin
      return ($signed(a) > $signed(b)) ? a : b;
    end
    return (a > b) ? a : b;
  endfunction

  logic advance;

  // ---------------------------------------------------------------------------
  // Tree levels. Level 0 reads the extended input vector; level k reads the
  // registers of level k-1. The lone element of an odd-sized level is
  // registered through unchanged.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_CNT = level_inputs(k);
    localparam int CNT    = level_count(k);

    word_t src [IN_CNT];
    logic  src_valid;
    logic  src_mode;
    logic  src_last;

    word_t d [CNT];

    word_t q [CNT];
    logic  q_valid;
    logic  q_mode;
    logic  q_last;

    if (k == 0) begin : g_entry
      for (genvar i = 0; i < IN_CNT; i++) begin : g_ext
        assign src[i] = extend(in_vector[i]);
      end
      assign src_valid = in_valid;
      assign src_mode  = in_mode;
      assign src_last  = in_last;
    end else begin : g_chain
      for (genvar i = 0; i < IN_CNT; i++) begin : g_link
        assign src[i] = g_level[k-1].q[i];
      end
      assign src_valid = g_level[k-1].q_valid;
      assign src_mode  = g_level[k-1].q_mode;
      assign src_last  = g_level[k-1].q_last;
    end

    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (2 * j + 1 < IN_CNT) begin : g_pair
        assign d[j] = combine(src[2*j], src[2*j+1], src_mode);
      end else begin : g_pass
        assign d[j] = src[2*j];
      end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every stage samples its predecessor's value from before the clock edge.
    // NOTE: the data registers are reset along with the valids because the
    // final stage drives out_data, which must read 0 during and after reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q_valid <= 1'b0;
        q_mode  <= 1'b0;
        q_last  <= 1'b0;
        for (int j = 0; j < CNT; j++) begin
          q[j] <= '0;
        end
      end else if (advance) begin
        // Bubbles are carried forward as-is; the pipe never collapses them.
        q_valid <= src_valid;
        q_mode  <= src_mode;
        q_last  <= src_last;
        for (int j = 0; j < CNT; j++) begin
          q[j] <= d[j];
        end
      end
    end
  end

  // Root of the tree: the last level always holds exactly one register.
  word_t tail_data;
  logic  tail_valid;
  logic  tail_mode;
  logic  tail_last;

  assign tail_data  = g_level[LEVELS-1].q[0];
  assign tail_valid = g_level[LEVELS-1].q_valid;
  assign tail_mode  = g_level[LEVELS-1].q_mode;
  assign tail_last  = g_level[LEVELS-1].q_last;

`ifdef ADDER_TREE_ACCUM_EN
  // ---------------------------------------------------------------------------
  // Accumulator stage. Results with last=0 fold into acc silently; a result
  // with last=1 emits the folded value and closes the group. acc_open tells
  // whether acc holds a partial group (otherwise the incoming result starts
  // a new one).
  // ---------------------------------------------------------------------------
  word_t acc;
  logic  acc_open;
  word_t res_data;
  logic  res_valid;
  logic  res_last;
  word_t folded;

  assign folded  = acc_open ? combine(acc, tail_data, tail_mode) : tail_data;
  assign advance = !res_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      acc_open  <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else if (advance) begin
      if (tail_valid && tail_last) begin
        res_data  <= folded;
        res_valid <= 1'b1;
        res_last  <= 1'b1;
        acc_open  <= 1'b0;
      end else if (tail_valid) begin
        acc       <= folded;
        acc_open  <= 1'b1;
        res_valid <= 1'b0;
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

  assign out_valid = res_valid;
  assign out_data  = res_data;
  assign out_last  = res_last;
`else
  // Without accumulation the tree root is the output register.
  logic unused_tail_mode;

  assign unused_tail_mode = tail_mode;
  assign advance          = !tail_valid || out_ready;
  assign out_valid        = tail_valid;
  assign out_data         = tail_data;
  assign out_last         = tail_last;
`endif

  // No skid buffer: the input side is ready exactly when the pipe may move.
  assign in_ready = advance;

endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// -----------------------------------------------------------------------------
// tb_pipelined_reduce_tree
//
// Directed, scoreboard-based bench for pipelined_reduce_tree. Four instances
// cover: N=8 unsigned (main), N=5 signed, N=4 width extreme, N=1 echo.
// Stimulus pushes hand-computed expected results into a per-instance queue;
// one monitor per instance pops and compares on every output transfer.
// Follows ADDER_TREE_ACCUM_EN so the same bench fits either build.
// -----------------------------------------------------------------------------
module tb_pipelined_reduce_tree;

`ifdef ADDER_TREE_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif
  localparam int LAT8 = 3 + int'(ACCUM);
  localparam int LAT1 = 1 + int'(ACCUM);

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic out_ready;

  // main: N=8, DATA_WIDTH=8, unsigned, OUT_WIDTH=11
  logic        m_in_valid, m_in_ready, m_in_mode, m_in_last, m_out_valid, m_out_last;
  logic [7:0]  m_vec [7:0];
  logic [10:0] m_out_data;
  // signed: N=5, DATA_WIDTH=8, OUT_WIDTH=11
  logic        s_in_valid, s_in_ready, s_in_mode, s_in_last, s_out_valid, s_out_last;
  logic [7:0]  s_vec [4:0];
  logic [10:0] s_out_data;
  // width: N=4, DATA_WIDTH=8, OUT_WIDTH=10
  logic        w_in_valid, w_in_ready, w_in_mode, w_in_last, w_out_valid, w_out_last;
  logic [7:0]  w_vec [3:0];
  logic [9:0]  w_out_data;
  // one: N=1, DATA_WIDTH=8, OUT_WIDTH=8
  logic        o_in_valid, o_in_ready, o_in_mode, o_in_last, o_out_valid, o_out_last;
  logic [7:0]  o_vec [0:0];
  logic [7:0]  o_out_data;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_w[$];
  exp_t q_o[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_reduce_tree #(.N(8), .DATA_WIDTH(8), .SIGNED(0)) u_main (
    .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_vector(m_vec), .in_mode(m_in_mode), .in_last(m_in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data), .out_last(m_out_last));

  pipelined_reduce_tree #(.N(5), .DATA_WIDTH(8), .SIGNED(1)) u_sgn (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_vector(s_vec), .in_mode(s_in_mode), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last));

  pipelined_reduce_tree #(.N(4), .DATA_WIDTH(8), .SIGNED(0)) u_wide (
    .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_vector(w_vec), .in_mode(w_in_mode), .in_last(w_in_last),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_last(w_out_last));

  pipelined_reduce_tree #(.N(1), .DATA_WIDTH(8), .SIGNED(0)) u_one (
    .clk(clk), .reset_n(reset_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_vector(o_vec), .in_mode(o_in_mode), .in_last(o_in_last),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data), .out_last(o_out_last));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic ready_of(input int dut);
    case (dut)
      0:       return m_in_ready;
      1:       return s_in_ready;
      2:       return w_in_ready;
      default: return o_in_ready;
    endcase
  endfunction

  // Presents one beat to instance `dut` (0 main, 1 signed, 2 wide, 3 one),
  // waits (bounded) for acceptance and, if `push`, queues the expected result.
  // Called and returns at posedge+1.
  task automatic send(input int dut, input logic [63:0] v, input logic mode, input logic last,
                      input logic push, input logic [31:0] exp_data, input logic exp_last);
    int   waited = 0;
    exp_t e;
    e.data = exp_data;
    e.last = exp_last;
    case (dut)
      0: begin
        for (int i = 0; i < 8; i++) m_vec[i] = v[8*i +: 8];
        m_in_mode = mode; m_in_last = last; m_in_valid = 1'b1;
      end
      1: begin
        for (int i = 0; i < 5; i++) s_vec[i] = v[8*i +: 8];
        s_in_mode = mode; s_in_last = last; s_in_valid = 1'b1;
      end
      2: begin
        for (int i = 0; i < 4; i++) w_vec[i] = v[8*i +: 8];
        w_in_mode = mode; w_in_last = last; w_in_valid = 1'b1;
      end
      default: begin
        o_vec[0] = v[7:0];
        o_in_mode = mode; o_in_last = last; o_in_valid = 1'b1;
      end
    endcase
    @(negedge clk);
    while (!ready_of(dut) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_of(dut)) begin
      check("send_ready_timeout", 32'(ready_of(dut)), 32'd1);
    end else if (push) begin
      case (dut)
        0:       q_m.push_back(e);
        1:       q_s.push_back(e);
        2:       q_w.push_back(e);
        default: q_o.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
    w_in_valid = 1'b0;
    o_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: pop and compare on every output transfer (sampled at negedge).
  // The main monitor also checks the stall rules: in_ready tracks the global
  // advance, and a held output stays unchanged.
  // ---------------------------------------------------------------------------
  logic        m_prev_stall = 1'b0;
  logic [10:0] m_prev_data;
  logic        m_prev_last;

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (reset_n) begin
      if (m_prev_stall) begin
        check("main_hold_valid", 32'(m_out_valid), 32'd1);
        check("main_hold_data", 32'(m_out_data), 32'(m_prev_data));
        check("main_hold_last", 32'(m_out_last), 32'(m_prev_last));
      end
      check("main_in_ready", 32'(m_in_ready), 32'(!m_out_valid || out_ready));
      if (m_out_valid && out_ready) begin
        if (q_m.size() == 0) begin
          check("main_spurious_valid", 32'(m_out_valid), 32'd0);
        end else begin
          e = q_m.pop_front();
          check("main_data", 32'(m_out_data), e.data);
          check("main_last", 32'(m_out_last), 32'(e.last));
        end
      end
      m_prev_stall = m_out_valid && !out_ready;
      m_prev_data  = m_out_data;
      m_prev_last  = m_out_last;
    end else begin
      m_prev_stall = 1'b0;
    end
  end

  always @(negedge clk) begin : mon_sgn
    exp_t e;
    if (reset_n && s_out_valid && out_ready) begin
      if (q_s.size() == 0) begin
        check("sgn_spurious_valid", 32'(s_out_valid), 32'd0);
      end else begin
        e = q_s.pop_front();
        check("sgn_data", 32'(s_out_data), e.data);
        check("sgn_last", 32'(s_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin : mon_wide
    exp_t e;
    if (reset_n && w_out_valid && out_ready) begin
      if (q_w.size() == 0) begin
        check("wide_spurious_valid", 32'(w_out_valid), 32'd0);
      end else begin
        e = q_w.pop_front();
        check("wide_data", 32'(w_out_data), e.data);
        check("wide_last", 32'(w_out_last), 32'(e.last));
      end
    end
  end

  always @(negedge clk) begin : mon_one
    exp_t e;
    if (reset_n && o_out_valid && out_ready) begin
      if (q_o.size() == 0) begin
        check("one_spurious_valid", 32'(o_out_valid), 32'd0);
      end else begin
        e = q_o.pop_front();
        check("one_data", 32'(o_out_data), e.data);
        check("one_last", 32'(o_out_last), 32'(e.last));
      end
    end
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int cyc;
    int n;

    reset_n    = 1'b0;
    out_ready  = 1'b1;
    m_in_valid = 1'b0; m_in_mode = 1'b0; m_in_last = 1'b0;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_in_last = 1'b0;
    w_in_valid = 1'b0; w_in_mode = 1'b0; w_in_last = 1'b0;
    o_in_valid = 1'b0; o_in_mode = 1'b0; o_in_last = 1'b0;
    for (int i = 0; i < 8; i++) m_vec[i] = '0;
    for (int i = 0; i < 5; i++) s_vec[i] = '0;
    for (int i = 0; i < 4; i++) w_vec[i] = '0;
    o_vec[0] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(m_out_valid), 32'd0);
    check("reset_out_data", 32'(m_out_data), 32'd0);
    check("reset_out_last", 32'(m_out_last), 32'd0);
    check("reset_in_ready", 32'(m_in_ready), 32'd1);
    check("reset_sgn_valid", 32'(s_out_valid), 32'd0);
    check("reset_one_valid", 32'(o_out_valid), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // Sum 1..8 = 36 with the LEVELS-cycle latency.
    send(0, mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 1'b1, 1'b1, 36, 1'b1);
    cyc = 1;
    while (!m_out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("main_latency", 32'(cyc), 32'(LAT8));
    idle(2);

    // Unsigned max: 255 must win over 254/200 under unsigned compare.
    send(0, mk(200, 3, 255, 17, 128, 0, 90, 254), 1'b1, 1'b1, 1'b1, 255, 1'b1);

    // Signed N=5 {-3, 7, -128, 7, 2}: max 7, sum -115 = 11'h78D = 1933.
    send(1, 64'h02_07_80_07_FD, 1'b1, 1'b1, 1'b1, 7, 1'b1);
    send(1, 64'h02_07_80_07_FD, 1'b0, 1'b1, 1'b1, 1933, 1'b1);
    // All negative {-3, -7, -128, -1, -2}: signed max -1 = 11'h7FF = 2047.
    send(1, 64'hFE_FF_80_F9_FD, 1'b1, 1'b1, 1'b1, 2047, 1'b1);

    // N=4 all 0xFF: 1020 on 10 bits; max of {1, 255, 128, 127} = 255.
    send(2, 64'hFF_FF_FF_FF, 1'b0, 1'b1, 1'b1, 1020, 1'b1);
    send(2, 64'h7F_80_FF_01, 1'b1, 1'b1, 1'b1, 255, 1'b1);

    // N=1 echoes the element after one cycle, in either mode.
    send(3, 64'hA5, 1'b0, 1'b1, 1'b1, 32'hA5, 1'b1);
    cyc = 1;
    while (!o_out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("one_latency", 32'(cyc), 32'(LAT1));
    send(3, 64'h3C, 1'b1, 1'b1, 1'b1, 32'h3C, 1'b1);
    idle(8);

    // Backpressure: 10 back-to-back vectors (all elements k+1, sum 8*(k+1)),
    // out_ready low for 4 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [7:0] b;
          b = 8'(k + 1);
          send(0, {8{b}}, 1'b0, 1'b1, 1'b1, 32'(8 * (k + 1)), 1'b1);
        end
      end
      begin
        idle(5);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_falls", 32'(m_in_ready), 32'd0);
        check("bp_out_valid_held", 32'(m_out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (q_m.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("bp_all_delivered", 32'(q_m.size()), 32'd0);
    idle(2);

    // Reset with three beats in flight (none expected to emerge).
    send(0, mk(100, 100, 100, 100, 100, 100, 100, 100), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    send(0, mk(50, 50, 50, 50, 50, 50, 50, 50), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    send(0, mk(9, 9, 9, 9, 9, 9, 9, 9), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_mid_out_data", 32'(m_out_data), 32'd0);
    check("rst_mid_out_last", 32'(m_out_last), 32'd0);
    check("rst_mid_in_ready", 32'(m_in_ready), 32'd1);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    check("rst_no_stale", 32'(m_out_valid), 32'd0);
    send(0, mk(10, 20, 30, 40, 50, 60, 70, 80), 1'b0, 1'b1, 1'b1, 360, 1'b1);
    idle(6);

    // Groups: sums 10, 20, 30 (last on third), then maxima 5, 9 (last on second).
    send(0, mk(1, 2, 3, 4, 0, 0, 0, 0), 1'b0, 1'b0, !ACCUM, 10, 1'b0);
    send(0, mk(5, 5, 5, 5, 0, 0, 0, 0), 1'b0, 1'b0, !ACCUM, 20, 1'b0);
    send(0, mk(1, 2, 3, 4, 5, 6, 7, 2), 1'b0, 1'b1, 1'b1, ACCUM ? 60 : 30, 1'b1);
    send(0, mk(1, 5, 2, 3, 0, 4, 5, 1), 1'b1, 1'b0, !ACCUM, 5, 1'b0);
    send(0, mk(9, 0, 0, 8, 1, 2, 3, 4), 1'b1, 1'b1, 1'b1, 9, 1'b1);

    // Drain and confirm every expected result was seen exactly once.
    n = 0;
    while ((q_m.size() + q_s.size() + q_w.size() + q_o.size()) != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    idle(4);
    check("final_main_queue", 32'(q_m.size()), 32'd0);
    check("final_sgn_queue", 32'(q_s.size()), 32'd0);
    check("final_wide_queue", 32'(q_w.size()), 32'd0);
    check("final_one_queue", 32'(q_o.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
